// File: rtl/stage_fetch_pkg.sv
// Shared fetch-stage definitions: nop encoding, default reset PC and the
// layout of the F/D pipeline latch.
package stage_fetch_pkg;

  localparam logic [31:0] NOP_INSN         = 32'd0;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;
  localparam int          DEFAULT_IMEM_AW  = 12;
  localparam logic [31:0] PC_STEP          = 32'd1;

  // Contents of the F/D latch handed to decode.
  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc_plus_1;
    logic        valid;
  } fd_latch_t;

endpackage

// File: rtl/stage_fetch_if.sv
// Fetch-stage bus: hazard/execute controls in, instruction-memory port,
// and the F/D latch outputs toward decode.
interface stage_fetch_if import stage_fetch_pkg::*; #(
  parameter int IMEM_AW = DEFAULT_IMEM_AW
);

  logic               stall;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_data;
  logic [31:0]        fd_insn;
  logic [31:0]        fd_pc_plus_1;
  logic [4:0]         fd_pc_upper_5;
  logic               fd_valid;

  // The fetch stage itself.
  modport master (
    input  stall, redirect, redirect_pc, imem_data,
    output imem_addr, fd_insn, fd_pc_plus_1, fd_pc_upper_5, fd_valid
  );

  // The surroundings: hazard unit, execute, instruction memory, decode.
  modport slave (
    output stall, redirect, redirect_pc, imem_data,
    input  imem_addr, fd_insn, fd_pc_plus_1, fd_pc_upper_5, fd_valid
  );

endinterface

// File: rtl/adder32.sv
// 32-bit ripple adder shared across the pipeline; sum wraps modulo 2^32.
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [32:0] full_s;

  // Widen to 33 bits so the carry-out falls out of the same add.
  always_comb begin
    full_s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
  end

  assign sum  = full_s[31:0];
  assign cout = full_s[32];

endmodule

// File: rtl/stage_fetch.sv
// Fetch stage: PC register, synchronous imem addressing with stall replay,
// and the F/D latch. Priority on each edge is reset > redirect > stall > advance.
module stage_fetch import stage_fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          IMEM_AW  = DEFAULT_IMEM_AW
) (
  input logic           clock,
  input logic           reset,
  stage_fetch_if.master bus
);

  logic [31:0]        pc_r;
  logic [31:0]        q_pc_r;
  logic               q_valid_r;
  fd_latch_t          fd_r;
  logic [31:0]        pc_inc_s;
  logic [31:0]        q_pc_inc_s;
  logic [IMEM_AW-1:0] imem_addr_s;

  // Next sequential PC.
  adder32 u_pc_inc (
    .a    (pc_r),
    .b    (PC_STEP),
    .cin  (1'b0),
    .sum  (pc_inc_s),
    .cout ()
  );

  // PC+1 of the in-flight fetch, latched alongside its instruction.
  adder32 u_q_pc_inc (
    .a    (q_pc_r),
    .b    (PC_STEP),
    .cin  (1'b0),
    .sum  (q_pc_inc_s),
    .cout ()
  );

  // Replay the in-flight address while stalled so imem_data stays aligned with q_pc.
  always_comb begin
    imem_addr_s = pc_r[IMEM_AW-1:0];
    if (bus.stall) begin
      imem_addr_s = q_pc_r[IMEM_AW-1:0];
    end else begin
      imem_addr_s = pc_r[IMEM_AW-1:0];
    end
  end

  // PC, in-flight fetch tracking and F/D latch update.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r         <= RESET_PC;
      q_pc_r       <= 32'd0;
      q_valid_r    <= 1'b0;
      fd_r.insn      <= NOP_INSN;
      fd_r.pc_plus_1 <= 32'd0;
      fd_r.valid     <= 1'b0;
    end else if (bus.redirect) begin
      // Squash the wrong-path fetch and F/D entry; pc_plus_1 is left as is.
      pc_r         <= bus.redirect_pc;
      q_valid_r    <= 1'b0;
      fd_r.insn    <= NOP_INSN;
      fd_r.valid   <= 1'b0;
    end else if (bus.stall) begin
      pc_r         <= pc_r;
      q_pc_r       <= q_pc_r;
      q_valid_r    <= q_valid_r;
      fd_r         <= fd_r;
    end else begin
      fd_r.insn      <= q_valid_r ? bus.imem_data : NOP_INSN;
      fd_r.valid     <= q_valid_r;
      fd_r.pc_plus_1 <= q_pc_inc_s;
      q_pc_r         <= pc_r;
      q_valid_r      <= 1'b1;
      pc_r           <= pc_inc_s;
    end
  end

  assign bus.imem_addr     = imem_addr_s;
  assign bus.fd_insn       = fd_r.insn;
  assign bus.fd_pc_plus_1  = fd_r.pc_plus_1;
  assign bus.fd_pc_upper_5 = fd_r.pc_plus_1[31:27];
  assign bus.fd_valid      = fd_r.valid;

endmodule

// File: tb/tb_stage_fetch.sv
// Directed bench for stage_fetch: two instances (RESET_PC 0 and 0xFFFF_FFFF)
// fed by behavioural synchronous memories holding 0x1000_0000 + address.
module tb_stage_fetch;

  localparam int AW = 12;

  logic clock = 1'b0;
  logic reset;
  int   checks_total  = 0;
  int   checks_passed = 0;

  stage_fetch_if #(.IMEM_AW(AW)) bus ();
  stage_fetch_if #(.IMEM_AW(AW)) bus2 ();

  stage_fetch #(.RESET_PC(32'd0), .IMEM_AW(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  stage_fetch #(.RESET_PC(32'hFFFF_FFFF), .IMEM_AW(AW)) dut_wrap (
    .clock (clock),
    .reset (reset),
    .bus   (bus2)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return 32'h1000_0000 + {20'd0, a};
  endfunction

  // Synchronous instruction memories: data one cycle after the address.
  always @(posedge clock) begin
    bus.imem_data  <= mem_word(bus.imem_addr);
    bus2.imem_data <= mem_word(bus2.imem_addr);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total = checks_total + 1;
    if (got === exp) begin
      checks_passed = checks_passed + 1;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_fd(input string tag, input logic [31:0] insn,
                          input logic [31:0] ppl1, input logic valid);
    check_eq({tag, ".insn"},  bus.fd_insn, insn);
    check_eq({tag, ".ppl1"},  bus.fd_pc_plus_1, ppl1);
    check_eq({tag, ".valid"}, 32'(bus.fd_valid), 32'(valid));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset            = 1'b1;
    bus.stall        = 1'b0;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = 32'd0;
    bus2.stall       = 1'b0;
    bus2.redirect    = 1'b0;
    bus2.redirect_pc = 32'd0;

    // Reset state
    step();
    check_fd("rst", 32'd0, 32'd0, 1'b0);
    check_eq("rst.upper5", 32'(bus.fd_pc_upper_5), 32'd0);
    check_eq("rst.addr", 32'(bus.imem_addr), 32'd0);
    check_eq("wrap.rst.addr", 32'(bus2.imem_addr), 32'h0000_0FFF);

    // Free run from reset: one nop bubble, then imem[0..]
    reset = 1'b0;
    step();
    check_eq("run.bubble.insn", bus.fd_insn, 32'd0);
    check_eq("run.bubble.valid", 32'(bus.fd_valid), 32'd0);
    check_eq("wrap.addr0", 32'(bus2.imem_addr), 32'd0);
    step();
    check_fd("run0", mem_word(12'd0), 32'd1, 1'b1);
    check_eq("wrap.first.insn", bus2.fd_insn, mem_word(12'hFFF));
    check_eq("wrap.first.ppl1", bus2.fd_pc_plus_1, 32'd0);
    check_eq("wrap.first.upper5", 32'(bus2.fd_pc_upper_5), 32'd0);
    step();
    check_fd("run1", mem_word(12'd1), 32'd2, 1'b1);
    check_eq("wrap.second.insn", bus2.fd_insn, mem_word(12'd0));
    check_eq("wrap.second.ppl1", bus2.fd_pc_plus_1, 32'd1);
    for (int i = 2; i <= 4; i++) begin
      step();
      check_fd("run", mem_word(AW'(i)), 32'(i + 1), 1'b1);
    end

    // 3-cycle stall holding imem[4]; imem address replays the in-flight one
    bus.stall = 1'b1;
    #1;
    check_eq("stall.addr", 32'(bus.imem_addr), 32'd5);
    for (int i = 0; i < 3; i++) begin
      step();
      check_fd("stall.hold", mem_word(12'd4), 32'd5, 1'b1);
    end
    bus.stall = 1'b0;
    step();
    check_fd("stall.rel5", mem_word(12'd5), 32'd6, 1'b1);

    // Redirect to 0x20 while F/D holds imem[5]
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0020;
    step();
    check_fd("redir.nop1", 32'd0, 32'd6, 1'b0);
    bus.redirect = 1'b0;
    step();
    check_fd("redir.nop2", 32'd0, 32'd7, 1'b0);
    step();
    check_fd("redir.tgt", mem_word(12'h020), 32'h0000_0021, 1'b1);

    // Redirect+stall together, then a back-to-back redirect that wins
    bus.stall       = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0040;
    step();
    check_fd("rr.first", 32'd0, 32'h0000_0021, 1'b0);
    bus.stall       = 1'b0;
    bus.redirect_pc = 32'h0000_0080;
    step();
    check_fd("rr.second", 32'd0, 32'h0000_0021, 1'b0);
    bus.redirect = 1'b0;
    step();
    check_fd("rr.bubble", 32'd0, 32'h0000_0022, 1'b0);
    step();
    check_fd("rr.tgt", mem_word(12'h080), 32'h0000_0081, 1'b1);

    // Reset during a stall with a valid F/D entry
    bus.stall = 1'b1;
    step();
    check_fd("rs.hold", mem_word(12'h080), 32'h0000_0081, 1'b1);
    reset = 1'b1;
    step();
    check_fd("rs.rst", 32'd0, 32'd0, 1'b0);
    check_eq("rs.addr", 32'(bus.imem_addr), 32'd0);
    reset     = 1'b0;
    bus.stall = 1'b0;
    step();
    check_eq("rs.bubble.valid", 32'(bus.fd_valid), 32'd0);
    step();
    check_fd("rs.refetch", mem_word(12'd0), 32'd1, 1'b1);

    // Upper-5 forwarding on a high target
    bus2.redirect    = 1'b1;
    bus2.redirect_pc = 32'hF800_0010;
    step();
    bus2.redirect = 1'b0;
    step();
    step();
    check_eq("hi.insn", bus2.fd_insn, mem_word(12'h010));
    check_eq("hi.ppl1", bus2.fd_pc_plus_1, 32'hF800_0011);
    check_eq("hi.upper5", 32'(bus2.fd_pc_upper_5), 32'h0000_001F);
    check_eq("hi.valid", 32'(bus2.fd_valid), 32'd1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/stage_fetch.md
# stage_fetch

Fetch stage of the 5-stage pipeline. Holds the PC, drives the synchronous instruction memory, and loads the F/D pipeline latch that feeds decode. It absorbs decode-stage stalls without losing the in-flight fetch. It consumes the redirect (branch/jump target) resolved in execute and squashes the younger wrong-path instructions it holds.

## Interface
- `RESET_PC`, default 32'd0: PC value loaded on reset.
- `IMEM_AW`, default 12: instruction-memory address width (word addressed).
- `clock` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: from the hazard unit; hold PC and the F/D latch.
- `redirect` in 1: from execute; asserted for j, jal, jr, and taken bne/blt/bex.
- `redirect_pc` in 32: from execute; the new PC (execute's `pc_in`).
- `imem_addr` out IMEM_AW: instruction-memory read address.
- `imem_data` in 32: instruction-memory read data, valid one cycle after the address.
- `fd_insn` out 32: instruction to decode; 32'd0 (nop) when not valid.
- `fd_pc_plus_1` out 32: PC+1 of `fd_insn`, forwarded to execute as `pc_plus_1`.
- `fd_pc_upper_5` out 5: `fd_pc_plus_1[31:27]`, forwarded as `pc_upper_5`.
- `fd_valid` out 1: F/D latch holds a real instruction.

## Operation
- State:
  - `pc` (32): next address to issue.
  - `q_pc` (32) and `q_valid`: the fetch currently in flight in imem.
  - F/D latch: `fd_insn`, `fd_pc_plus_1`, `fd_valid`.
- Address mux: `imem_addr = stall ? q_pc[IMEM_AW-1:0] : pc[IMEM_AW-1:0]`. During a stall the in-flight address is replayed, so `imem_data` stays aligned with `q_pc` for the whole stall.
- Per-edge priority: reset > redirect > stall > advance.
  - **reset**: `pc <= RESET_PC`; `q_valid <= 0`; `q_pc <= 0`; `fd_insn <= 0`; `fd_pc_plus_1 <= 0`; `fd_valid <= 0`.
  - **redirect** (stall is ignored): `pc <= redirect_pc`; `q_valid <= 0`; `fd_insn <= 0`; `fd_valid <= 0`. `fd_pc_plus_1` holds its value. Squashing the D/X latch is decode's responsibility, not this block's.
  - **stall**: all state holds.
  - **advance**:
    - `fd_insn <= q_valid ? imem_data : 0`
    - `fd_valid <= q_valid`
    - `fd_pc_plus_1 <= q_pc + 1`
    - `q_pc <= pc`; `q_valid <= 1`
    - `pc <= pc + 1`
- Arithmetic: PC+1 is a 32-bit add that wraps modulo 2^32 (0xFFFFFFFF -> 0). `imem_addr` is the low `IMEM_AW` bits of the PC, so the address wraps at 2^IMEM_AW.
- Nop encoding is 32'd0. An invalid F/D entry must always present 32'd0 on `fd_insn`.

## Timing
- Reset values: `fd_insn` = 0, `fd_pc_plus_1` = 0, `fd_pc_upper_5` = 0, `fd_valid` = 0, `imem_addr` = `RESET_PC[IMEM_AW-1:0]`.
- Fetch latency: address issued in cycle t; data reaches `fd_insn` after edge t+2.
- After reset deasserts at edge E, the first instruction (address `RESET_PC`) is on `fd_insn` after edge E+2, with one nop bubble after E+1.
- Redirect penalty: after the redirect edge, two nop cycles on F/D; the target instruction appears after the second following edge.
- Stall of N cycles: F/D and PC hold for exactly N edges. The sequence on release is the same as without the stall: no duplicate, no skipped instruction.
- Redirect asserted together with stall: the redirect takes effect on that edge.
- Redirect in the cycle right after another redirect: the second one wins. The first target never reaches F/D.
- `reset` asserted mid-stream: all in-flight and latched instructions are discarded on that edge.

## Structure
- Shared define include file carries `NOP_INSN` (32'd0) and the default `RESET_PC`. Decode and the D/X/M/W latches use the same file.
- PC+1 uses the existing `adder32` (cin = 0, flag outputs unused). The same instance is not reused for `q_pc + 1`; that path uses its own `adder32`.
- No FSM module; the block is a flat register set plus the address mux.

## Test plan
- **Reset then free run**, imem[i] = 0x1000_0000 + i: `fd_insn` = 0 for 2 cycles after release, then imem[0], [1], [2] with `fd_pc_plus_1` = 1, 2, 3.
- **3-cycle stall while `fd_insn` = imem[4]**: imem[4] is held for 4 cycles total, then imem[5], imem[6] follow with no gap or repeat.
- **Redirect to 0x20 while F/D holds imem[5]**: two cycles with `fd_insn` = 0 and `fd_valid` = 0, then imem[0x20] with `fd_pc_plus_1` = 0x21.
- **Redirect and stall in the same cycle, then redirects on back-to-back cycles to 0x40 and 0x80**: only imem[0x80] appears; 0x40 is never latched.
- **PC wrap**: `RESET_PC` = 0xFFFF_FFFF gives `fd_pc_plus_1` = 0 for the first instruction, and `imem_addr` cycles 0xFFF -> 0x000.
- **Reset asserted during a stall with valid F/D**: outputs return to reset values on the next edge, and the refetch starts at `RESET_PC`.
